conv2d_naive: RTL and testbench

- Naive 2-D convolution accelerator.
- Fetches a WT_DIM×WT_DIM weight kernel and an fm_dim×fm_dim input feature map (IFM) from data memory through a ready/valid read/write port pair.
- Produces a same-size output feature map (OFM), zero-padded at the borders, and writes it back to memory.
- Sits between the CPU control logic (start/idle/done, offsets) and the memory-side IO controller in front of the dual-port DMem.

---
 rtl/conv2d_naive.sv | 216 +++++++++++++++++++++
 tb/tb_conv2d_naive.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv2d_naive.sv
// Naive WT_DIM x WT_DIM 2-D convolution over an fm_dim x fm_dim feature map with zero halo.
// Define CONV2D_ZERO_SKIP_EN to skip IFM reads for taps whose weight is zero.
module conv2d_naive #(
  parameter int AWIDTH = 14,
  parameter int DWIDTH = 32,
  parameter int WT_DIM = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              idle,
  output logic              done,
  input  logic [31:0]       fm_dim,
  input  logic [31:0]       wt_offset,
  input  logic [31:0]       ifm_offset,
  input  logic [31:0]       ofm_offset,
  output logic [AWIDTH-1:0] req_read_addr,
  output logic              req_read_addr_valid,
  input  logic              req_read_addr_ready,
  output logic [31:0]       req_read_len,
  input  logic [DWIDTH-1:0] resp_read_data,
  input  logic              resp_read_data_valid,
  output logic              resp_read_data_ready,
  output logic [AWIDTH-1:0] req_write_addr,
  output logic              req_write_addr_valid,
  input  logic              req_write_addr_ready,
  output logic [31:0]       req_write_len,
  output logic [DWIDTH-1:0] req_write_data,
  output logic              req_write_data_valid,
  input  logic              req_write_data_ready,
  output logic [DWIDTH-1:0] resp_write_status,
  output logic              resp_write_status_valid,
  input  logic              resp_write_status_ready
);
  localparam int NW = WT_DIM * WT_DIM;
  localparam int KW = (NW > 1) ? $clog2(NW) : 1;
  localparam int MW = (WT_DIM > 1) ? $clog2(WT_DIM) : 1;
  localparam logic signed [33:0] HALO = 34'(WT_DIM / 2);
  localparam logic [MW-1:0] TAP_MAX = MW'(WT_DIM - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_REQ, S_LOAD_RESP, S_TAP, S_READ_REQ, S_READ_RESP, S_WRITE, S_DONE
  } state_t;

  state_t            state;
  logic [31:0]       fm_reg, wt_off_reg, ifm_off_reg, ofm_off_reg;
  logic [DWIDTH-1:0] wt_regs [NW];
  logic [KW-1:0]     k_reg;
  logic [31:0]       y_reg, x_reg;
  logic [MW-1:0]     m_reg, n_reg;
  logic [DWIDTH-1:0] acc_reg;

  logic signed [33:0] iy, ix, fm_s;
  logic              halo, skip, tap_last, pix_last;
  logic [KW-1:0]     w_idx;
  logic [DWIDTH-1:0] cur_w, acc_sum;
  logic [31:0]       tap_addr, ofm_addr, ld_addr;
  logic [MW-1:0]     m_adv, n_adv;
  logic              unused_status_ready;

  assign req_read_len            = 32'd1;
  assign req_write_len           = 32'd1;
  assign resp_write_status       = '0;
  assign resp_write_status_valid = 1'b0;
  assign unused_status_ready     = resp_write_status_ready;

  always_comb begin
    iy       = $signed({2'b00, y_reg}) + $signed({{(34-MW){1'b0}}, m_reg}) - HALO;
    ix       = $signed({2'b00, x_reg}) + $signed({{(34-MW){1'b0}}, n_reg}) - HALO;
    fm_s     = $signed({2'b00, fm_reg});
    halo     = iy[33] || ix[33] || (iy >= fm_s) || (ix >= fm_s);
    w_idx    = KW'(int'(m_reg) * WT_DIM + int'(n_reg));
    cur_w    = wt_regs[w_idx];
`ifdef CONV2D_ZERO_SKIP_EN
    skip     = halo || (cur_w == '0);
`else
    skip     = halo;
`endif
    acc_sum  = acc_reg + resp_read_data * cur_w;
    tap_addr = ifm_off_reg + iy[31:0] * fm_reg + ix[31:0];
    ofm_addr = ofm_off_reg + y_reg * fm_reg + x_reg;
    ld_addr  = wt_off_reg + 32'(k_reg) + 32'd1;
    tap_last = (m_reg == TAP_MAX) && (n_reg == TAP_MAX);
    pix_last = (x_reg == fm_reg - 32'd1) && (y_reg == fm_reg - 32'd1);
    n_adv    = (n_reg == TAP_MAX) ? '0 : n_reg + 1'b1;
    m_adv    = (n_reg == TAP_MAX) ? m_reg + 1'b1 : m_reg;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state                <= S_IDLE;
      idle                 <= 1'b1;
      done                 <= 1'b0;
      fm_reg               <= '0;
      wt_off_reg           <= '0;
      ifm_off_reg          <= '0;
      ofm_off_reg          <= '0;
      for (int i = 0; i < NW; i++) wt_regs[i] <= '0;
      k_reg                <= '0;
      y_reg                <= '0;
      x_reg                <= '0;
      m_reg                <= '0;
      n_reg                <= '0;
      acc_reg              <= '0;
      req_read_addr        <= '0;
      req_read_addr_valid  <= 1'b0;
      resp_read_data_ready <= 1'b0;
      req_write_addr       <= '0;
      req_write_addr_valid <= 1'b0;
      req_write_data       <= '0;
      req_write_data_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          fm_reg      <= fm_dim;
          wt_off_reg  <= wt_offset;
          ifm_off_reg <= ifm_offset;
          ofm_off_reg <= ofm_offset;
          done        <= 1'b0;
          idle        <= 1'b0;
          k_reg       <= '0;
          y_reg       <= '0;
          x_reg       <= '0;
          m_reg       <= '0;
          n_reg       <= '0;
          acc_reg     <= '0;
          // An empty map needs neither the kernel nor any IFM data.
          if (fm_dim == 32'd0) begin
            state <= S_DONE;
          end else begin
            req_read_addr       <= wt_offset[AWIDTH-1:0];
            req_read_addr_valid <= 1'b1;
            state               <= S_LOAD_REQ;
          end
        end
        S_LOAD_REQ, S_READ_REQ: if (req_read_addr_ready) begin
          req_read_addr_valid  <= 1'b0;
          resp_read_data_ready <= 1'b1;
          state                <= (state == S_LOAD_REQ) ? S_LOAD_RESP : S_READ_RESP;
        end
        S_LOAD_RESP: if (resp_read_data_valid) begin
          resp_read_data_ready <= 1'b0;
          wt_regs[k_reg]       <= resp_read_data;
          if (k_reg == KW'(NW - 1)) begin
            state <= S_TAP;
          end else begin
            k_reg               <= k_reg + 1'b1;
            req_read_addr       <= ld_addr[AWIDTH-1:0];
            req_read_addr_valid <= 1'b1;
            state               <= S_LOAD_REQ;
          end
        end
        S_TAP: begin
          if (skip) begin
            m_reg <= m_adv;
            n_reg <= n_adv;
            if (tap_last) begin
              req_write_addr       <= ofm_addr[AWIDTH-1:0];
              req_write_data       <= acc_reg;
              req_write_addr_valid <= 1'b1;
              req_write_data_valid <= 1'b1;
              state                <= S_WRITE;
            end
          end else begin
            req_read_addr       <= tap_addr[AWIDTH-1:0];
            req_read_addr_valid <= 1'b1;
            state               <= S_READ_REQ;
          end
        end
        S_READ_RESP: if (resp_read_data_valid) begin
          resp_read_data_ready <= 1'b0;
          acc_reg              <= acc_sum;
          m_reg                <= m_adv;
          n_reg                <= n_adv;
          if (tap_last) begin
            req_write_addr       <= ofm_addr[AWIDTH-1:0];
            req_write_data       <= acc_sum;
            req_write_addr_valid <= 1'b1;
            req_write_data_valid <= 1'b1;
            state                <= S_WRITE;
          end else begin
            state <= S_TAP;
          end
        end
        S_WRITE: begin
          if (req_write_addr_ready) req_write_addr_valid <= 1'b0;
          if (req_write_data_ready) req_write_data_valid <= 1'b0;
          // Address and data channels may complete on different cycles.
          if ((!req_write_addr_valid || req_write_addr_ready) &&
              (!req_write_data_valid || req_write_data_ready)) begin
            acc_reg <= '0;
            m_reg   <= '0;
            n_reg   <= '0;
            if (pix_last) begin
              state <= S_DONE;
            end else begin
              state <= S_TAP;
              if (x_reg == fm_reg - 32'd1) begin
                x_reg <= '0;
                y_reg <= y_reg + 32'd1;
              end else begin
                x_reg <= x_reg + 32'd1;
              end
            end
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          idle  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv2d_naive.sv
// Self-checking bench for conv2d_naive: reactive memory model with optional stalls/latency and an OFM write scoreboard.
module tb_conv2d_naive;
  localparam int AW = 14;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst, start, idle, done;
  logic [31:0]   fm_dim, wt_offset, ifm_offset, ofm_offset;
  logic [AW-1:0] req_read_addr, req_write_addr;
  logic          req_read_addr_valid, req_read_addr_ready;
  logic [31:0]   req_read_len, req_write_len;
  logic [DW-1:0] resp_read_data, req_write_data, resp_write_status;
  logic          resp_read_data_valid, resp_read_data_ready;
  logic          req_write_addr_valid, req_write_addr_ready;
  logic          req_write_data_valid, req_write_data_ready;
  logic          resp_write_status_valid, resp_write_status_ready;

  always #5 clk = ~clk;

  conv2d_naive #(.AWIDTH(AW), .DWIDTH(DW), .WT_DIM(3)) dut (
    .clk(clk), .rst(rst), .start(start), .idle(idle), .done(done),
    .fm_dim(fm_dim), .wt_offset(wt_offset), .ifm_offset(ifm_offset), .ofm_offset(ofm_offset),
    .req_read_addr(req_read_addr), .req_read_addr_valid(req_read_addr_valid),
    .req_read_addr_ready(req_read_addr_ready), .req_read_len(req_read_len),
    .resp_read_data(resp_read_data), .resp_read_data_valid(resp_read_data_valid),
    .resp_read_data_ready(resp_read_data_ready),
    .req_write_addr(req_write_addr), .req_write_addr_valid(req_write_addr_valid),
    .req_write_addr_ready(req_write_addr_ready), .req_write_len(req_write_len),
    .req_write_data(req_write_data), .req_write_data_valid(req_write_data_valid),
    .req_write_data_ready(req_write_data_ready),
    .resp_write_status(resp_write_status), .resp_write_status_valid(resp_write_status_valid),
    .resp_write_status_ready(resp_write_status_ready)
  );

  typedef struct {logic [31:0] addr; logic [31:0] data;} wr_t;

  logic [31:0] mem [0:255];
  wr_t         exp_q [$];
  int          compared = 0, mismatched = 0;
  int          n_reads = 0, n_writes = 0;
  bit          stall = 1'b0;
  int          lat = 0;

  bit            r_fire, rbusy, aw_got, w_got, ar_hold, aw_hold, w_hold;
  int            rlat;
  logic [AW-1:0] raddr, waddr, ar_a, aw_a;
  logic [31:0]   wdata, w_d;
  wr_t           e;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference convolution from the current memory image, queued in write order.
  task automatic push_expected(input int fm, input int wo, input int io, input int oo);
    logic [31:0] acc;
    int iy, ix;
    for (int y = 0; y < fm; y++) begin
      for (int x = 0; x < fm; x++) begin
        acc = 32'd0;
        for (int m = 0; m < 3; m++) begin
          for (int n = 0; n < 3; n++) begin
            iy = y + m - 1;
            ix = x + n - 1;
            if (iy >= 0 && iy < fm && ix >= 0 && ix < fm)
              acc = acc + mem[io + iy * fm + ix] * mem[wo + m * 3 + n];
          end
        end
        exp_q.push_back('{addr: 32'(oo + y * fm + x), data: acc});
      end
    end
  endtask

  task automatic launch(input int fm, input int wo, input int io, input int oo);
    fm_dim = 32'(fm); wt_offset = 32'(wo); ifm_offset = 32'(io); ofm_offset = 32'(oo);
    n_reads = 0; n_writes = 0;
    push_expected(fm, wo, io, oo);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_done_low", done, 0);
    check("start_idle_low", idle, 0);
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    while (!done && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    check("done_within_budget", done, 1);
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  // Memory controller model: decisions made at negedge take effect at the next posedge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        r_fire = 0; rbusy = 0; rlat = 0; aw_got = 0; w_got = 0;
        ar_hold = 0; aw_hold = 0; w_hold = 0;
        req_read_addr_ready = 0; resp_read_data_valid = 0;
        req_write_addr_ready = 0; req_write_data_ready = 0;
        continue;
      end
      if (ar_hold) check("rd_addr_stable", {req_read_addr_valid, req_read_addr}, {1'b1, ar_a});
      if (aw_hold) check("wr_addr_stable", {req_write_addr_valid, req_write_addr}, {1'b1, aw_a});
      if (w_hold) check("wr_data_stable", {req_write_data_valid, req_write_data}, {1'b1, w_d});

      if (r_fire) begin resp_read_data_valid = 0; rbusy = 0; r_fire = 0; end
      if (rbusy && !resp_read_data_valid) begin
        if (rlat > 0) rlat--;
        else begin resp_read_data_valid = 1; resp_read_data = mem[raddr[7:0]]; end
      end
      if (resp_read_data_ready) check("rd_ready_only_when_awaiting", rbusy, 1);
      if (resp_read_data_valid && resp_read_data_ready) r_fire = 1;

      req_read_addr_ready = !rbusy && (!stall || $urandom_range(0, 1) == 1);
      ar_hold = req_read_addr_valid && !req_read_addr_ready;
      ar_a = req_read_addr;
      if (req_read_addr_valid && req_read_addr_ready) begin
        rbusy = 1; rlat = lat; raddr = req_read_addr; n_reads++;
        if (req_read_addr > 255) check("rd_addr_range", req_read_addr, 0);
      end

      req_write_addr_ready = !aw_got && (!stall || $urandom_range(0, 1) == 1);
      req_write_data_ready = !w_got && (!stall || $urandom_range(0, 1) == 1);
      aw_hold = req_write_addr_valid && !req_write_addr_ready;
      w_hold = req_write_data_valid && !req_write_data_ready;
      aw_a = req_write_addr;
      w_d = req_write_data;
      if (req_write_addr_valid && req_write_addr_ready) begin aw_got = 1; waddr = req_write_addr; end
      if (req_write_data_valid && req_write_data_ready) begin w_got = 1; wdata = req_write_data; end
      if (aw_got && w_got) begin
        aw_got = 0; w_got = 0; n_writes++;
        $display("write addr=%0d data=%0d", waddr, wdata);
        if (waddr < 256) mem[waddr[7:0]] = wdata;
        if (exp_q.size() == 0) begin
          check("write_expected", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("write_addr", 32'(waddr), e.addr);
          check("write_data", wdata, e.data);
        end
      end
    end
  end

  int cyc, rd_snap, wr_snap;
  int spot_idx [7] = '{0, 1, 7, 8, 9, 15, 63};
  int spot_val [7] = '{5, 17, 79, 6, 21, 99, 79};
  int wts [9] = '{1, 2, 1, 4, 5, 4, 1, 2, 1};

  initial begin
    rst = 0; start = 0; fm_dim = 0; wt_offset = 0; ifm_offset = 0; ofm_offset = 0;
    resp_read_data = 0; resp_read_data_valid = 0; req_read_addr_ready = 0;
    req_write_addr_ready = 0; req_write_data_ready = 0; resp_write_status_ready = 0;
    for (int i = 0; i < 256; i++) mem[i] = 0;
    for (int k = 0; k < 9; k++) mem[k] = 32'(wts[k]);
    for (int i = 0; i < 64; i++) mem[9 + i] = 32'(i % 8);

    repeat (10) @(negedge clk);
    check("reset_idle", idle, 1);
    check("reset_done", done, 0);
    check("reset_rd_valid", req_read_addr_valid, 0);
    check("reset_wr_addr_valid", req_write_addr_valid, 0);
    check("reset_wr_data_valid", req_write_data_valid, 0);
    check("reset_rd_ready", resp_read_data_ready, 0);
    @(posedge clk); #1 rst = 1;
    @(negedge clk);

    $display("run default fm_dim=8");
    launch(8, 0, 9, 73);
    wait_done(50000, cyc);
    check("default_reads", n_reads, 493);
    check("default_writes", n_writes, 64);
    for (int i = 0; i < 7; i++) check("default_ofm_spot", mem[73 + spot_idx[i]], 32'(spot_val[i]));
    repeat (5) @(negedge clk);
    check("done_held", done, 1);
    check("idle_after_done", idle, 1);

    $display("run backpressure fm_dim=8 latency=10");
    for (int i = 0; i < 64; i++) mem[73 + i] = 0;
    stall = 1; lat = 10;
    launch(8, 0, 9, 73);
    wait_done(50000, cyc);
    check("bp_reads", n_reads, 493);
    check("bp_writes", n_writes, 64);
    for (int i = 0; i < 7; i++) check("bp_ofm_spot", mem[73 + spot_idx[i]], 32'(spot_val[i]));

    $display("run fm_dim=1");
    stall = 0; lat = 0;
    mem[9] = 7; mem[73] = 0;
    launch(1, 0, 9, 73);
    wait_done(1000, cyc);
    check("fm1_writes", n_writes, 1);
    check("fm1_reads", n_reads, 10);
    check("fm1_ofm", mem[73], 35);

    $display("run restart with new ifm, start while busy ignored");
    for (int i = 0; i < 64; i++) mem[9 + i] = $urandom_range(0, 1000);
    stall = 1; lat = 3;
    launch(8, 0, 9, 73);
    repeat (100) @(negedge clk);
    check("busy_idle_low", idle, 0);
    fm_dim = 2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    fm_dim = 8;
    wait_done(50000, cyc);
    check("restart_writes", n_writes, 64);

    $display("run fm_dim=0");
    stall = 0; lat = 0;
    launch(0, 0, 9, 73);
    wait_done(1, cyc);
    check("fm0_reads", n_reads, 0);
    check("fm0_writes", n_writes, 0);

    $display("run reset mid-operation");
    stall = 1; lat = 2;
    launch(8, 0, 9, 73);
    repeat (300) @(negedge clk);
    @(posedge clk); #1 rst = 0;
    repeat (3) @(negedge clk);
    check("midrst_idle", idle, 1);
    check("midrst_done", done, 0);
    check("midrst_rd_valid", req_read_addr_valid, 0);
    check("midrst_wr_valid", req_write_addr_valid | req_write_data_valid, 0);
    exp_q.delete();
    @(posedge clk); #1 rst = 1;
    rd_snap = n_reads; wr_snap = n_writes;
    repeat (30) @(negedge clk);
    check("midrst_no_reads", n_reads, rd_snap);
    check("midrst_no_writes", n_writes, wr_snap);
    check("midrst_still_idle", idle, 1);

    $display("run after reset fm_dim=8");
    launch(8, 0, 9, 73);
    wait_done(50000, cyc);
    check("post_rst_writes", n_writes, 64);
    check("post_rst_reads", n_reads, 493);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
